// File: rtl/inst_fetch_responder_pkg.sv
// inst_fetch_responder_pkg: shared types and default sizes for the fetch responder
// Build option: ICACHE_EN adds a direct-mapped instruction cache.
package inst_fetch_responder_pkg;
  localparam int RAM_ADDR_W_DEF = 17;
  localparam int ICACHE_LINES_DEF = 64;
  typedef enum logic {IF_IDLE, IF_FETCH} if_state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] word;
  } result_buf_t;
endpackage

// File: rtl/inst_fetch_responder_if.sv
// inst_fetch_responder_if: fetch request/done handshake plus byte-wide RAM port
// master: IF stage and RAM side (drives ram_request, pc_i, flush, mem_din)
// slave:  responder (drives ram_done, inst_i_o, mem_a, mem_wr)
interface inst_fetch_responder_if #(parameter int RAM_ADDR_W = 17) ();
  logic                  ram_request;
  logic [31:0]           pc_i;
  logic                  ram_done;
  logic [31:0]           inst_i_o;
  logic                  flush;
  logic [RAM_ADDR_W-1:0] mem_a;
  logic                  mem_wr;
  logic [7:0]            mem_din;
  modport master (output ram_request, pc_i, flush, mem_din, input ram_done, inst_i_o, mem_a, mem_wr);
  modport slave (input ram_request, pc_i, flush, mem_din, output ram_done, inst_i_o, mem_a, mem_wr);
endinterface

// File: rtl/inst_fetch_responder_icache_dm.sv
// icache_dm: direct-mapped one-word-per-line instruction cache (exists only with ICACHE_EN)
// Ports: clk, rst (async active-low), rd_addr -> hit/rd_word, write port we/wr_addr/wr_word.
`ifdef ICACHE_EN
module icache_dm import inst_fetch_responder_pkg::*; #(parameter int LINES = ICACHE_LINES_DEF) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_addr,
  output logic        hit,
  output logic [31:0] rd_word,
  input  logic        we,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_word
);
  localparam int IW = $clog2(LINES);
  logic [LINES-1:0] vld;
  logic [31-IW:0] tags [LINES];
  logic [31:0] data [LINES];
  logic [IW-1:0] ri, wi;
  assign ri = rd_addr[2+:IW];
  assign wi = wr_addr[2+:IW];
  // tag keeps the byte-offset bits too so unaligned pcs never alias an aligned line
  assign hit = vld[ri] & (tags[ri] == {rd_addr[31:2+IW], rd_addr[1:0]});
  assign rd_word = data[ri];
  always_ff @(posedge clk or negedge rst)
    if (!rst) vld <= '0;
    else if (we) vld[wi] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[wi] <= {wr_addr[31:2+IW], wr_addr[1:0]};
      data[wi] <= wr_word;
    end
endmodule
`endif

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: serves IF fetch requests by reading 4 RAM bytes into a little-endian word
// Ports: clk, rst (async active-low), bus (slave modport: request/done handshake + RAM port).
// Build option: ICACHE_EN enables the icache_dm hit path (done one cycle after request).
module inst_fetch_responder import inst_fetch_responder_pkg::*; #(
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
  parameter int ICACHE_LINES = ICACHE_LINES_DEF
) (
  input logic clk,
  input logic rst,
  inst_fetch_responder_if.slave bus
);
  if_state_e state, state_nx;
  result_buf_t rbuf;
  logic [31:0] p;
  logic [2:0] cnt;
  logic [23:0] bytes;
  logic [RAM_ADDR_W-1:0] ma;
  logic done_w, abort, start, last, hit;
  logic [31:0] hit_word;
  always_comb begin
    done_w = rbuf.valid & bus.ram_request & (rbuf.addr == bus.pc_i);
    abort = bus.flush | ~bus.ram_request | (bus.pc_i != p);
    start = (state == IF_IDLE) & bus.ram_request & ~done_w & ~bus.flush;
    last = (state == IF_FETCH) & ~abort & (cnt == 3'd4);
  end
`ifdef ICACHE_EN
  icache_dm #(.LINES(ICACHE_LINES)) u_icache (
    .clk(clk), .rst(rst), .rd_addr(bus.pc_i), .hit(hit), .rd_word(hit_word),
    .we(last), .wr_addr(p), .wr_word({bus.mem_din, bytes})
  );
`else
  assign hit = 1'b0;
  assign hit_word = '0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IF_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IF_IDLE) ? ((start & ~hit) ? IF_FETCH : IF_IDLE)
                                  : ((abort | cnt == 3'd4) ? IF_IDLE : IF_FETCH);
  always_comb begin
    bus.ram_done = done_w;
    bus.inst_i_o = done_w ? rbuf.word : '0;
    bus.mem_a = ma;
    bus.mem_wr = 1'b0;
  end
  // cnt counts FETCH cycles from 0: addresses go out for cnt 0..3, bytes arrive for cnt 1..4
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rbuf <= '0;
      p <= '0;
      cnt <= '0;
      bytes <= '0;
      ma <= '0;
    end else begin
      if (start) begin
        p <= bus.pc_i;
        cnt <= '0;
        if (!hit) ma <= bus.pc_i[RAM_ADDR_W-1:0];
      end
      if (state == IF_FETCH && !abort) begin
        cnt <= cnt + 3'd1;
        if (cnt < 3'd3) ma <= p[RAM_ADDR_W-1:0] + RAM_ADDR_W'(cnt + 3'd1);
        if (cnt != 3'd0) bytes <= {bus.mem_din, bytes[23:8]};
      end
      if (bus.flush) rbuf.valid <= 1'b0;
      else if (last) rbuf <= '{valid: 1'b1, addr: p, word: {bus.mem_din, bytes}};
      else if (start && hit) rbuf <= '{valid: 1'b1, addr: bus.pc_i, word: hit_word};
    end
endmodule
